// File: rtl/wb_master_pkg.sv
//------------------------------------------------------------------------------
// wb_master_pkg
// Shared types and constants for the Wishbone command initiator.
//   state_e    : initiator FSM states (IDLE, BUS, RESP)
//   ST_OK      : bus cycle terminated by ack
//   ST_ERR     : bus cycle terminated by err (err wins over a simultaneous ack)
//   ST_TIMEOUT : bus cycle aborted because no ack/err arrived in time
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package wb_master_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ERR     = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_cmd_master.sv
//------------------------------------------------------------------------------
// wb_cmd_master
// Wishbone classic initiator. Takes one read/write command on a valid/ready
// port, runs a single-beat bus cycle, and returns data + status on a
// valid/ready response port. Every bus cycle is bounded by a timeout.
//
// Ports
//   wb_clk_i, wb_rst_ni         : clock, asynchronous active-low reset
//   cmd_valid/ready             : command handshake (ready only in IDLE)
//   cmd_we/addr/wdata/sel       : command fields, latched on acceptance
//   rsp_valid/ready             : response handshake
//   rsp_rdata, rsp_status       : read data (0 unless OK read), 00 OK/01 ERR/10 TIMEOUT
//   wbm_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o : registered Wishbone master outputs
//   wbm_dat_i/ack_i/err_i       : Wishbone slave returns
//   busy                        : high whenever the FSM is not in IDLE
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_cmd_master
   import wb_master_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [DW-1:0]   cmd_wdata,
   input  logic [DW/8-1:0] cmd_sel,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_rdata,
   output logic [1:0]      rsp_status,
   output logic            wbm_cyc_o,
   output logic            wbm_stb_o,
   output logic            wbm_we_o,
   output logic [AW-1:0]   wbm_adr_o,
   output logic [DW-1:0]   wbm_dat_o,
   output logic [DW/8-1:0] wbm_sel_o,
   input  logic [DW-1:0]   wbm_dat_i,
   input  logic            wbm_ack_i,
   input  logic            wbm_err_i,
   output logic            busy
);

   // $clog2(1) is 0, so clamp the counter to at least one bit.
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   // Counter value during the last permitted strobe cycle.
   localparam logic [CW-1:0] TC_LAST =
      CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   state_e            state_q,  state_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic              cyc_q,    cyc_d;
   logic              we_q,     we_d;
   logic [AW-1:0]     adr_q,    adr_d;
   logic [DW-1:0]     dat_q,    dat_d;
   logic [DW/8-1:0]   sel_q,    sel_d;
   logic              rvalid_q, rvalid_d;
   logic [DW-1:0]     rdata_q,  rdata_d;
   logic [1:0]        status_q, status_d;
   logic              timeout_hit;

   // A zero timeout disables the abort path entirely.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TC_LAST);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      sel_d    = sel_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      status_d = status_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = BUS;
               cnt_d   = '0;
               cyc_d   = 1'b1;
               we_d    = cmd_we;
               adr_d   = cmd_addr;
               dat_d   = cmd_wdata;
               sel_d   = cmd_sel;
            end
         end

         BUS: begin
            if (wbm_ack_i || wbm_err_i || timeout_hit) begin
               // Any termination: drop the bus, clear the request fields and
               // present the response on the next cycle.
               state_d  = RESP;
               cnt_d    = '0;
               cyc_d    = 1'b0;
               we_d     = 1'b0;
               adr_d    = '0;
               dat_d    = '0;
               sel_d    = '0;
               rvalid_d = 1'b1;
               rdata_d  = '0;
               if (wbm_err_i) begin
                  status_d = ST_ERR;
               end else if (wbm_ack_i) begin
                  status_d = ST_OK;
                  if (!we_q) begin
                     rdata_d = wbm_dat_i;
                  end
               end else begin
                  status_d = ST_TIMEOUT;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         RESP: begin
            if (rsp_ready) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
               rdata_d  = '0;
               status_d = ST_OK;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         status_q <= ST_OK;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = cyc_q;
   assign wbm_we_o   = we_q;
   assign wbm_adr_o  = adr_q;
   assign wbm_dat_o  = dat_q;
   assign wbm_sel_o  = sel_q;
   assign rsp_valid  = rvalid_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_status = status_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
//------------------------------------------------------------------------------
// tb_wb_cmd_master
// Drives commands into wb_cmd_master with a scripted Wishbone slave and checks
// every transaction against a reference of the expected outcome.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_cmd_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 8;

   // Slave response modes
   localparam int M_NONE = 0;
   localparam int M_ACK  = 1;
   localparam int M_ERR  = 2;
   localparam int M_BOTH = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [DW/8-1:0] cmd_sel;
   logic            rsp_valid, rsp_ready;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_status;
   logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [AW-1:0]   wbm_adr_o;
   logic [DW-1:0]   wbm_dat_o;
   logic [DW/8-1:0] wbm_sel_o;
   logic [DW-1:0]   wbm_dat_i;
   logic            wbm_ack_i, wbm_err_i;
   logic            busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(T)) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_sel    (cmd_sel),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_status (rsp_status),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_we_o   (wbm_we_o),
      .wbm_adr_o  (wbm_adr_o),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_sel_o  (wbm_sel_o),
      .wbm_dat_i  (wbm_dat_i),
      .wbm_ack_i  (wbm_ack_i),
      .wbm_err_i  (wbm_err_i),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // One complete transaction: command, scripted slave, response wait.
   // The expected outcome is derived from the slave script alone.
   task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW/8-1:0] sel,
                          input logic [DW-1:0] sdat, input int mode,
                          input int delay, input int rwait);
      int          exp_n, n;
      logic [1:0]  exp_st;
      logic [DW-1:0] exp_rd;
      bit          done;

      if (mode != M_NONE && delay < T) begin
         exp_n  = delay + 1;
         exp_st = (mode == M_ACK) ? 2'b00 : 2'b01;
         exp_rd = (mode == M_ACK && !we) ? sdat : '0;
      end else begin
         exp_n  = T;
         exp_st = 2'b10;
         exp_rd = '0;
      end

      // Offer the command at a falling edge, accepted at the next rising edge.
      check("idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
      wbm_dat_i = sdat;
      @(posedge clk); @(negedge clk);
      // Junk on the command port must be ignored until the next IDLE.
      cmd_valid = 1'b1; cmd_we = ~we; cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_sel = 4'($urandom);
      check("cyc_after_accept", wbm_cyc_o, 1);

      n = 0; done = 0;
      for (int c = 0; c < 4 * T && !done; c++) begin
         if (wbm_cyc_o) begin
            check("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
            check("bus_we",     wbm_we_o,  we);
            check("bus_adr",    wbm_adr_o, addr);
            check("bus_dat",    wbm_dat_o, wdata);
            check("bus_sel",    wbm_sel_o, sel);
            check("bus_cmd_ready", cmd_ready, 0);
            wbm_ack_i = (n == delay) && (mode == M_ACK || mode == M_BOTH);
            wbm_err_i = (n == delay) && (mode == M_ERR || mode == M_BOTH);
            n++;
            @(posedge clk); @(negedge clk);
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
         end else begin
            done = 1;
         end
      end
      if (!done) check("bus_cycle_bound", 0, 1);

      check("stb_cycles",   n, exp_n);
      check("rsp_valid",    rsp_valid, 1);
      check("rsp_status",   rsp_status, exp_st);
      check("rsp_rdata",    rsp_rdata, exp_rd);
      check("idle_bus_fields", {wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}, 0);

      // Backpressure: response must hold; stray acks must not disturb it.
      for (int w = 0; w < rwait; w++) begin
         wbm_ack_i = 1'($urandom);
         @(posedge clk); @(negedge clk);
         wbm_ack_i = 1'b0;
         check("hold_valid",  rsp_valid, 1);
         check("hold_status", rsp_status, exp_st);
         check("hold_rdata",  rsp_rdata, exp_rd);
         check("hold_cmd_ready", cmd_ready, 0);
         check("hold_cyc", wbm_cyc_o, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check("post_rsp_valid", rsp_valid, 0);
      check("post_cmd_ready", cmd_ready, 1);
      check("post_busy", busy, 0);
      check("post_cyc", wbm_cyc_o, 0);
      $display("txn we=%0d adr=%08h mode=%0d dly=%0d rwait=%0d -> n=%0d st=%0d rd=%08h",
               we, addr, mode, delay, rwait, n, rsp_status === 2'bxx ? 0 : exp_st, exp_rd);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_sel = '0; rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_cyc", wbm_cyc_o, 0);
      check("rst_stb", wbm_stb_o, 0);
      check("rst_bus_fields", {wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}, 0);
      check("rst_rsp", {rsp_valid, rsp_rdata, rsp_status}, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0BAD_F00D, M_ACK, 2, 0);
      run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h1234_5678, M_ACK, 0, 1);
      run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'hCAFE_0001, M_NONE, 0, 0);
      run_txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, 32'hCAFE_0002, M_BOTH, 1, 0);
      run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'hCAFE_0003, M_ACK, T - 1, 0);
      run_txn(1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'h1, 32'h0, M_ERR, T - 1, 5);

      // Stray ack in IDLE must be ignored
      wbm_ack_i = 1'b1; wbm_err_i = 1'b1;
      @(posedge clk); @(negedge clk);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      check("stray_idle_busy", busy, 0);
      check("stray_idle_rsp", rsp_valid, 0);
      check("stray_idle_cyc", wbm_cyc_o, 0);

      // Reset in the middle of a bus cycle
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h3000_0020; cmd_wdata = 32'h1111_2222;
      cmd_sel = 4'hF;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      check("pre_rst_cyc", wbm_cyc_o, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_cyc", wbm_cyc_o, 0);
      check("midrst_stb", wbm_stb_o, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("after_rst_rsp_valid", rsp_valid, 0);
      run_txn(1'b1, 32'h3000_0024, 32'h3333_4444, 4'hC, 32'h0, M_ACK, 1, 2);

      // Randomized transactions
      for (int i = 0; i < 60; i++) begin
         int m, d;
         m = $urandom_range(3, 0);
         d = ($urandom_range(4, 0) == 0) ? T - 1 : $urandom_range(T + 3, 0);
         run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, m, d,
                 $urandom_range(5, 0));
         if ($urandom_range(3, 0) == 0) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog: never let the run hang.
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
